// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes decoded instruction descriptors into 32-bit MIPS words and
// writes them to instruction memory at consecutive word addresses.
// Optional feature macro: INST_ENC_NOP_PAD_EN -- after the last instruction, fill every
// remaining address up to the top of memory with nop (32'h00000000).
module inst_encoder_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int INST_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            OpSel,
  input  logic [2:0]            AluFn,
  input  logic [4:0]            Rs,
  input  logic [4:0]            Rt,
  input  logic [4:0]            Rd,
  input  logic [15:0]           Imm,
  input  logic [25:0]           Target,
  input  logic                  Last,
  output logic                  IMemWrite,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  output logic [INST_WIDTH-1:0] IMemWData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_WIDTH:0]   InstCount
);

`ifdef INST_ENC_NOP_PAD_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, PAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;

  state_t      state;
  logic        last_q;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] enc;
  logic        desc_ok;

  // Combinational encoder: opcode/funct lookup and field packing for the presented descriptor
  always_comb begin
    funct   = AluFn == 3'd0 ? 6'b100100 :
              AluFn == 3'd1 ? 6'b100101 :
              AluFn == 3'd2 ? 6'b100000 :
              AluFn == 3'd3 ? 6'b100010 :
              AluFn == 3'd4 ? 6'b101010 : 6'b011100;
    opcode  = OpSel == 3'd0 ? 6'b100011 :
              OpSel == 3'd1 ? 6'b101011 :
              OpSel == 3'd3 ? 6'b001000 :
              OpSel == 3'd4 ? 6'b000100 :
              OpSel == 3'd5 ? 6'b000010 : 6'b000000;
    enc     = OpSel == 3'd5 ? {opcode, Target} :
              OpSel == 3'd2 ? {opcode, Rs, Rt, Rd, 5'd0, funct} :
                              {opcode, Rs, Rt, Imm};
    desc_ok = (OpSel <= 3'd5) && (OpSel != 3'd2 || AluFn <= 3'd5);
  end

  // Loader FSM with registered handshake, memory-port and status outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      last_q    <= 1'b0;
      InReady   <= 1'b0;
      IMemWrite <= 1'b0;
      IMemAddr  <= '0;
      IMemWData <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      InstCount <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= LOAD;
            IMemAddr  <= '0;
            InstCount <= '0;
            Error     <= 1'b0;
            Done      <= 1'b0;
            InReady   <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (InValid && desc_ok) begin
            state     <= WRITE;
            IMemWData <= INST_WIDTH'(enc);
            last_q    <= Last;
            IMemWrite <= 1'b1;
            InReady   <= 1'b0;
          end else if (InValid) begin
            Error <= 1'b1;
          end
        end
        WRITE: begin
          IMemAddr  <= IMemAddr + 1'b1;
          InstCount <= InstCount + 1'b1;
          if (last_q) begin
`ifdef INST_ENC_NOP_PAD_EN
            if (IMemAddr != MAX_ADDR) begin
              state     <= PAD;
              IMemWData <= '0;
            end else begin
              state     <= DONE;
              IMemWrite <= 1'b0;
              Busy      <= 1'b0;
              Done      <= 1'b1;
            end
`else
            state     <= DONE;
            IMemWrite <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
`endif
          end else if (IMemAddr == MAX_ADDR) begin
            state     <= DONE;
            IMemWrite <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Error     <= 1'b1;
          end else begin
            state     <= LOAD;
            IMemWrite <= 1'b0;
            InReady   <= 1'b1;
          end
        end
`ifdef INST_ENC_NOP_PAD_EN
        PAD: begin
          IMemAddr <= IMemAddr + 1'b1;
          if (IMemAddr == MAX_ADDR) begin
            state     <= DONE;
            IMemWrite <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: randomized self-checking bench for inst_encoder_loader against a descriptor-level model
module tb_inst_encoder_loader;
  localparam int AW  = 6;
  localparam int DEP = 1 << AW;

  logic        CLK = 0, RST = 0, Start = 0, InValid = 0, Last = 0;
  logic [2:0]  OpSel = 0, AluFn = 0;
  logic [4:0]  Rs = 0, Rt = 0, Rd = 0;
  logic [15:0] Imm = 0;
  logic [25:0] Target = 0;
  logic        InReady, IMemWrite, Busy, Done, Error;
  logic [AW-1:0] IMemAddr;
  logic [31:0] IMemWData;
  logic [AW:0] InstCount;

  inst_encoder_loader #(.ADDR_WIDTH(AW), .INST_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .InValid(InValid), .InReady(InReady),
    .OpSel(OpSel), .AluFn(AluFn), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm), .Target(Target),
    .Last(Last), .IMemWrite(IMemWrite), .IMemAddr(IMemAddr), .IMemWData(IMemWData),
    .Busy(Busy), .Done(Done), .Error(Error), .InstCount(InstCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tg;
    logic        last;
  } desc_t;

  int nvec = 0, nerr = 0, cyc = 0;
  desc_t prog[$];
  int wq_a[$], wc[$], exp_a[$];
  logic [31:0] wq_d[$], exp_d[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    if (IMemWrite) begin
      wq_a.push_back(int'(IMemAddr));
      wq_d.push_back(IMemWData);
      wc.push_back(cyc);
    end

  function automatic bit valid_desc(desc_t d);
    return d.op <= 5 && (d.op != 2 || d.fn <= 5);
  endfunction

  function automatic logic [31:0] encode(desc_t d);
    logic [5:0] f;
    case (d.fn)
      0: f = 6'h24; 1: f = 6'h25; 2: f = 6'h20;
      3: f = 6'h22; 4: f = 6'h2A; default: f = 6'h1C;
    endcase
    case (d.op)
      0: return {6'h23, d.rs, d.rt, d.imm};
      1: return {6'h2B, d.rs, d.rt, d.imm};
      2: return {6'h00, d.rs, d.rt, d.rd, 5'd0, f};
      3: return {6'h08, d.rs, d.rt, d.imm};
      4: return {6'h04, d.rs, d.rt, d.imm};
      default: return {6'h02, d.tg};
    endcase
  endfunction

  function automatic desc_t rnd_desc(bit allow_bad, bit last);
    desc_t d;
    d.op   = allow_bad ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
    d.fn   = (allow_bad && $urandom_range(0, 3) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    d.rs   = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom);
    d.imm  = 16'($urandom); d.tg = 26'($urandom);
    d.last = last;
    return d;
  endfunction

  function automatic desc_t mk(logic [2:0] op, logic [2:0] fn, logic [4:0] rs, logic [4:0] rt,
                               logic [4:0] rd, logic [15:0] imm, logic [25:0] tg, logic last);
    desc_t d;
    d.op = op; d.fn = fn; d.rs = rs; d.rt = rt; d.rd = rd; d.imm = imm; d.tg = tg; d.last = last;
    return d;
  endfunction

  task automatic do_start();
    @(negedge CLK);
    Start = 1;
    @(negedge CLK);
    Start = 0;
  endtask

  task automatic send(input desc_t d, output bit ok);
    ok = 0;
    OpSel = d.op; AluFn = d.fn; Rs = d.rs; Rt = d.rt; Rd = d.rd;
    Imm = d.imm; Target = d.tg; Last = d.last; InValid = 1;
    for (int k = 0; k < 20; k++) begin
      if (Done) break;
      if (InReady) begin
        ok = 1;
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
    end
    InValid = 0;
  endtask

  task automatic wait_done(string name);
    int k;
    for (k = 0; k < 400 && !Done; k++) @(negedge CLK);
    nvec++;
    if (!Done) begin
      nerr++;
      $display("FAIL %s done_timeout: Done=%0b after %0d cycles, required 1", name, Done, k);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_prog(string name, bit check_spacing);
    int addr = 0, exp_cnt = 0, exp_acc = 0, acc = 0;
    bit exp_err = 0, fin = 0, ok;
    exp_a.delete(); exp_d.delete();
    foreach (prog[i]) begin
      if (fin) break;
      exp_acc++;
      if (!valid_desc(prog[i])) begin exp_err = 1; continue; end
      exp_a.push_back(addr); exp_d.push_back(encode(prog[i])); exp_cnt++;
      if (prog[i].last) begin
`ifdef INST_ENC_NOP_PAD_EN
        for (int a = addr + 1; a < DEP; a++) begin exp_a.push_back(a); exp_d.push_back(32'h0); end
`endif
        fin = 1;
      end else if (addr == DEP - 1) begin
        exp_err = 1; fin = 1;
      end else addr++;
    end
    wq_a.delete(); wq_d.delete(); wc.delete();
    do_start();
    foreach (prog[i]) begin
      if (Done) break;
      send(prog[i], ok);
      if (ok) acc++;
    end
    wait_done(name);
    nvec++;
    if (acc !== exp_acc) begin nerr++; $display("FAIL %s accepted: got %0d, required %0d", name, acc, exp_acc); end
    nvec++;
    if (wq_a.size() !== exp_a.size()) begin
      nerr++; $display("FAIL %s write_count: got %0d, required %0d", name, wq_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < wq_a.size(); i++) begin
      nvec++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
        nerr++;
        $display("FAIL %s write[%0d]: got addr %0d data %h, required addr %0d data %h",
                 name, i, wq_a[i], wq_d[i], exp_a[i], exp_d[i]);
      end
    end
    nvec++;
    if (InstCount !== (AW+1)'(exp_cnt)) begin nerr++; $display("FAIL %s InstCount: got %0d, required %0d", name, InstCount, exp_cnt); end
    nvec++;
    if (Error !== exp_err) begin nerr++; $display("FAIL %s Error: got %0b, required %0b", name, Error, exp_err); end
    nvec++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin nerr++; $display("FAIL %s final_status: got Done=%0b Busy=%0b, required 1 0", name, Done, Busy); end
    if (check_spacing)
      for (int i = 1; i < exp_cnt && i < wc.size(); i++) begin
        nvec++;
        if (wc[i] - wc[i-1] !== 2) begin nerr++; $display("FAIL %s spacing[%0d]: got %0d cycles, required 2", name, i, wc[i] - wc[i-1]); end
      end
  endtask

  task automatic check_zero(string name);
    nvec++;
    if ({InReady, IMemWrite, Busy, Done, Error} !== 5'b0 || IMemAddr !== '0 || IMemWData !== 32'h0 || InstCount !== '0) begin
      nerr++;
      $display("FAIL %s outputs: got rdy=%0b we=%0b busy=%0b done=%0b err=%0b addr=%0d data=%h cnt=%0d, required all 0",
               name, InReady, IMemWrite, Busy, Done, Error, IMemAddr, IMemWData, InstCount);
    end
  endtask

  task automatic test_reset();
    RST = 0;
    repeat (2) @(negedge CLK);
    check_zero("reset");
    RST = 1;
    @(negedge CLK);
    check_zero("idle_after_reset");
  endtask

  task automatic test_single();
    prog.delete();
    prog.push_back(mk(0, 0, 2, 3, 0, 16'h0004, 0, 1));
    run_prog("single_lw", 0);
    nvec++;
    if (wq_d.size() < 1 || wq_d[0] !== 32'h8C430004 || wq_a[0] !== 0) begin
      nerr++; $display("FAIL single_lw word0: got %h, required 8c430004 at 0", wq_d.size() ? wq_d[0] : 32'hx);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fx[3] = '{6'b100010, 6'b101010, 6'b011100};
    prog.delete();
    prog.push_back(mk(2, 2, 1, 2, 3, 0, 0, 0));
    prog.push_back(mk(2, 3, 4, 5, 6, 0, 0, 0));
    prog.push_back(mk(2, 4, 7, 8, 9, 0, 0, 0));
    prog.push_back(mk(2, 5, 10, 11, 12, 0, 0, 0));
    prog.push_back(mk(5, 0, 0, 0, 0, 0, 26'h10, 1));
    run_prog("rtype", 1);
    nvec++;
    if (wq_d.size() < 5 || wq_d[0] !== 32'h00221820 || wq_d[4] !== 32'h08000010) begin
      nerr++; $display("FAIL rtype const_words: got %0d writes, required 00221820 ... 08000010", wq_d.size());
    end
    for (int i = 0; i < 3 && i + 1 < wq_d.size(); i++) begin
      nvec++;
      if (wq_d[i+1][5:0] !== fx[i] || wq_d[i+1][31:26] !== 6'b0) begin
        nerr++; $display("FAIL rtype funct[%0d]: got %b, required %b", i + 1, wq_d[i+1][5:0], fx[i]);
      end
    end
  endtask

  task automatic test_invalid();
    bit ok;
    desc_t lw = mk(0, 7, 9, 10, 0, 16'hBEEF, 0, 1);
    wq_a.delete(); wq_d.delete(); wc.delete();
    do_start();
    send(mk(7, 0, 1, 1, 1, 1, 1, 0), ok);
    nvec++;
    if (Error !== 1'b1 || IMemWrite !== 1'b0 || InReady !== 1'b1) begin
      nerr++; $display("FAIL invalid_op status: got err=%0b we=%0b rdy=%0b, required 1 0 1", Error, IMemWrite, InReady);
    end
    send(mk(2, 6, 1, 1, 1, 1, 1, 0), ok);
    nvec++;
    if (IMemAddr !== '0 || InstCount !== '0 || wq_a.size() !== 0 || Error !== 1'b1) begin
      nerr++; $display("FAIL invalid_fn state: got addr=%0d cnt=%0d writes=%0d err=%0b, required 0 0 0 1", IMemAddr, InstCount, wq_a.size(), Error);
    end
    send(lw, ok);
    wait_done("invalid_then_lw");
    nvec++;
    if (wq_a.size() < 1 || wq_a[0] !== 0 || wq_d[0] !== encode(lw) || Error !== 1'b1 || InstCount !== 1) begin
      nerr++; $display("FAIL invalid_then_lw write: got %0d writes cnt=%0d err=%0b, required lw at 0 cnt=1 err=1", wq_a.size(), InstCount, Error);
    end
  endtask

  task automatic test_full();
    prog.delete();
    for (int i = 0; i < DEP + 1; i++) prog.push_back(rnd_desc(0, i == DEP));
    run_prog("mem_full", 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 25);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rnd_desc(1, i == n - 1));
      if (!valid_desc(prog[n-1])) prog[n-1].op = 3'($urandom_range(0, 5));
      if (prog[n-1].op == 2) prog[n-1].fn = 3'($urandom_range(0, 5));
      run_prog($sformatf("random%0d", r), 0);
    end
  endtask

  task automatic test_reset_write();
    bit ok;
    do_start();
    send(mk(3, 0, 1, 2, 0, 16'h1234, 0, 0), ok);
    nvec++;
    if (IMemWrite !== 1'b1 || !ok) begin nerr++; $display("FAIL rst_write in_write: got we=%0b, required 1", IMemWrite); end
    #1 RST = 0;
    #1 check_zero("async_reset");
    @(negedge CLK);
    RST = 1;
    prog.delete();
    prog.push_back(mk(1, 0, 5, 6, 0, 16'h0010, 0, 1));
    run_prog("reload_after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rtype();
    test_invalid();
    test_full();
    test_random();
    test_reset_write();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
